a5_1_sequencer: RTL and testbench
=================================

// Module: a5_1_sequencer
// PURPOSE
// - Controls the three A5/1 LFSRs (X 19b, Y 22b, Z 23b) for the image-encrypt datapath.
// - Each LFSR instance exposes shift_bit, trigger, out_reg and a majority-tap output.
// - Sequence per session: clear, key load, frame load, majority-clocked mixing, then
//   keystream output. Keystream leaves on a valid/ready stream, one bit per transfer.
// PARAMETERS
// - KEY_W       64   key bits loaded, LSB first
// - FRAME_W     22   frame-number bits loaded, LSB first
// - MIX_CYCLES  101  majority clocks before the first keystream bit is presented (100 discarded + 1)
// - KS_BITS     228  keystream bits per session
// PORTS
// - clk           in   1        clock, rising edge
// - reset         in   1        asynchronous, active-high
// - start         in   1        session request; accepted only in IDLE
// - abort         in   1        synchronous abort; returns to IDLE
// - key           in   KEY_W    session key; sampled on start acceptance
// - frame         in   FRAME_W  frame number; sampled on start acceptance
// - busy          out  1        high in every state except IDLE
// - done          out  1        one-cycle pulse after the last keystream transfer
// - reg_clear     out  1        registered pulse; top level ORs it into all LFSR resets
// - x_shift_bit, y_shift_bit, z_shift_bit  out  1  serial load bit to each LFSR
// - x_trigger, y_trigger, z_trigger        out  1  clock enable to each LFSR
// - x_out, y_out, z_out                    in   1  LFSR MSB outputs
// - x_maj, y_maj, z_maj                    in   1  LFSR clocking taps (X[8], Y[10], Z[10])
// - ks_bit        out  1        keystream bit = x_out ^ y_out ^ z_out
// - ks_valid      out  1        ks_bit valid
// - ks_ready      in   1        consumer accepts ks_bit
// - ks_last       out  1        marks the KS_BITS-th bit
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; counter 0; key and frame latches 0.
// - States and transitions:
//   - IDLE: start -> CLEAR; latch key and frame.
//   - CLEAR: 1 cycle; reg_clear=1; -> KEY.
//   - KEY: KEY_W cycles; all triggers=1; shift_bits=key[cnt]; -> FRAME.
//   - FRAME: FRAME_W cycles; all triggers=1; shift_bits=frame[cnt]; -> MIX.
//   - MIX: MIX_CYCLES cycles of majority clocking; shift_bits=0; -> STREAM.
//   - STREAM: ks_valid=1; each ks_valid&&ks_ready transfer majority-clocks once and
//     increments cnt. The transfer with cnt==KS_BITS-1 (ks_last=1) -> IDLE with done=1.
// - Majority clocking: maj = (x_maj&y_maj)|(x_maj&z_maj)|(y_maj&z_maj); r_trigger = (r_maj==maj).
//   At least two triggers are always high.
// - Outside KEY, FRAME, MIX and STREAM transfers: triggers=0, shift_bits=0.
// - Triggers, shift bits, ks_bit, ks_valid and ks_last are combinational from state, cnt,
//   the LFSR inputs and ks_ready. State, cnt and reg_clear are registered.
// - Backpressure: with ks_ready=0 in STREAM, triggers=0, ks_bit is held stable and cnt holds.
// - cnt is one shared $clog2(max phase length) counter; it clears on every state change.
// - start while busy is ignored; key and frame changes while busy have no effect.
// - abort beats start and beats a simultaneous final transfer: next state IDLE, done=0.
//   An aborted session leaves LFSR contents undefined; the next session starts with CLEAR.
// - reset mid-operation: immediate IDLE, outputs 0; LFSRs are cleared by the same reset.
// - Latency: start to first ks_valid = 1+KEY_W+FRAME_W+MIX_CYCLES+1 cycles (189 at defaults).
// STRUCTURE
// - Package a5_1_pkg: state encoding, LFSR widths 19/22/23, majority tap indices, default
//   KEY_W/FRAME_W/MIX_CYCLES/KS_BITS constants.
// - Sub-module a5_1_majority: combinational maj and trigger generation from the three taps
//   plus an enable input. The FSM, counter and stream logic stay in this module.
// TESTING
// - Reset: outputs all 0, busy=0. start, then reset asserted in KEY -> IDLE same edge,
//   triggers=0, no done.
// - key=64'h0123456789ABCDEF, frame=22'h134: in KEY, shift_bits per cycle = 1,1,1,1,0,1,1,1,
//   with triggers all 1 for exactly 64 cycles. In FRAME: 0,0,1,0,1,1,0,0,1,0,0 then 0s,
//   22 cycles.
// - MIX with taps (1,1,0) -> x/y triggers 1, z 0; taps (0,0,0) -> all 1; MIX lasts exactly 101 cycles.
// - key=0, frame=0, ks_ready=1: 228 transfers of ks_bit=0; ks_last only on the 228th;
//   done pulse the next cycle; busy=0 after.
// - Backpressure: ks_ready=0 for 5 cycles after the 10th transfer -> triggers 0, ks_bit
//   stable, total transfers still 228.
// - With real LFSRs and key=0x123456789ABCDEF0, frame=22'h2A: the 228-bit keystream
//   matches the C reference model. Then abort mid-STREAM followed by a new start gives the
//   same keystream again.

Source files
------------

// File: rtl/a5_1_pkg.sv
// Shared definitions for the A5/1 keystream sequencer: phase encoding, register
// geometry, default session sizing and small combinational helpers.
package a5_1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_KEY    = 3'd2,
    ST_FRAME  = 3'd3,
    ST_MIX    = 3'd4,
    ST_STREAM = 3'd5
  } state_e;

  localparam int LFSR_X_W = 19;
  localparam int LFSR_Y_W = 22;
  localparam int LFSR_Z_W = 23;

  localparam int X_MAJ_IDX = 8;
  localparam int Y_MAJ_IDX = 10;
  localparam int Z_MAJ_IDX = 10;

  localparam int KEY_W_DEF      = 64;
  localparam int FRAME_W_DEF    = 22;
  localparam int MIX_CYCLES_DEF = 101;
  localparam int KS_BITS_DEF    = 228;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_1_majority.sv
// Majority-clock trigger generation: a register steps when its clocking tap agrees
// with the majority of the three taps, so at least two registers always step.
module a5_1_majority
  import a5_1_pkg::*;
(
  input  logic en_i,
  input  logic x_maj_i,
  input  logic y_maj_i,
  input  logic z_maj_i,
  output logic x_trig_o,
  output logic y_trig_o,
  output logic z_trig_o
);

  logic maj_s;

  // Vote and per-register agreement, suppressed when not clocking
  always_comb begin
    maj_s = maj3(x_maj_i, y_maj_i, z_maj_i);
    if (en_i) begin
      x_trig_o = (x_maj_i == maj_s);
      y_trig_o = (y_maj_i == maj_s);
      z_trig_o = (z_maj_i == maj_s);
    end else begin
      x_trig_o = 1'b0;
      y_trig_o = 1'b0;
      z_trig_o = 1'b0;
    end
  end

endmodule

// File: rtl/a5_1_sequencer.sv
// Session sequencer for the three A5/1 registers: clear, key load, frame load,
// majority mixing, then a valid/ready keystream of KS_BITS single-bit transfers.
module a5_1_sequencer
  import a5_1_pkg::*;
#(
  parameter int KEY_W      = KEY_W_DEF,
  parameter int FRAME_W    = FRAME_W_DEF,
  parameter int MIX_CYCLES = MIX_CYCLES_DEF,
  parameter int KS_BITS    = KS_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [KEY_W-1:0]   key,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               done,
  output logic               reg_clear,
  output logic               x_shift_bit,
  output logic               y_shift_bit,
  output logic               z_shift_bit,
  output logic               x_trigger,
  output logic               y_trigger,
  output logic               z_trigger,
  input  logic               x_out,
  input  logic               y_out,
  input  logic               z_out,
  input  logic               x_maj,
  input  logic               y_maj,
  input  logic               z_maj,
  output logic               ks_bit,
  output logic               ks_valid,
  input  logic               ks_ready,
  output logic               ks_last
);

  localparam int CNT_W    = $clog2(max4(KEY_W, FRAME_W, MIX_CYCLES, KS_BITS));
  localparam int KEY_IW   = $clog2(KEY_W);
  localparam int FRAME_IW = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
  localparam logic [CNT_W-1:0] KS_LAST    = CNT_W'(KS_BITS - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [KEY_W-1:0]   key_q;
  logic [FRAME_W-1:0] frame_q;
  logic               reg_clear_q;
  logic               done_q;

  logic load_s;
  logic shift_s;
  logic maj_en_s;
  logic ks_valid_s;
  logic x_mtrig_s;
  logic y_mtrig_s;
  logic z_mtrig_s;

  // Phase FSM with one shared counter that restarts at every phase change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_q       <= '0;
      frame_q     <= '0;
      reg_clear_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      reg_clear_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q     <= ST_CLEAR;
              cnt_q       <= '0;
              key_q       <= key;
              frame_q     <= frame;
              reg_clear_q <= 1'b1;
            end
          end
          ST_CLEAR: begin
            state_q <= ST_KEY;
            cnt_q   <= '0;
          end
          ST_KEY: begin
            if (cnt_q == KEY_LAST) begin
              state_q <= ST_FRAME;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_FRAME: begin
            if (cnt_q == FRAME_LAST) begin
              state_q <= ST_MIX;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_MIX: begin
            if (cnt_q == MIX_LAST) begin
              state_q <= ST_STREAM;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_STREAM: begin
            if (ks_ready) begin
              if (cnt_q == KS_LAST) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                done_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Load vs. majority clocking and the serial load bit for the current phase
  always_comb begin
    load_s     = 1'b0;
    shift_s    = 1'b0;
    maj_en_s   = 1'b0;
    ks_valid_s = 1'b0;
    case (state_q)
      ST_KEY: begin
        load_s  = 1'b1;
        shift_s = key_q[cnt_q[KEY_IW-1:0]];
      end
      ST_FRAME: begin
        load_s  = 1'b1;
        shift_s = frame_q[cnt_q[FRAME_IW-1:0]];
      end
      ST_MIX: begin
        maj_en_s = 1'b1;
      end
      ST_STREAM: begin
        ks_valid_s = 1'b1;
        maj_en_s   = ks_ready;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  a5_1_majority u_majority (
    .en_i     (maj_en_s),
    .x_maj_i  (x_maj),
    .y_maj_i  (y_maj),
    .z_maj_i  (z_maj),
    .x_trig_o (x_mtrig_s),
    .y_trig_o (y_mtrig_s),
    .z_trig_o (z_mtrig_s)
  );

  assign x_trigger   = load_s | x_mtrig_s;
  assign y_trigger   = load_s | y_mtrig_s;
  assign z_trigger   = load_s | z_mtrig_s;
  assign x_shift_bit = shift_s;
  assign y_shift_bit = shift_s;
  assign z_shift_bit = shift_s;

  // The output bit only advances on a transfer, so it holds while stalled
  assign ks_valid  = ks_valid_s;
  assign ks_bit    = ks_valid_s & (x_out ^ y_out ^ z_out);
  assign ks_last   = ks_valid_s & (cnt_q == KS_LAST);
  assign busy      = (state_q != ST_IDLE);
  assign reg_clear = reg_clear_q;
  assign done      = done_q;

endmodule

// File: tb/tb_a5_1_sequencer.sv
// Bench for a5_1_sequencer: behavioural A5/1 registers around the DUT, a timeline
// model of the session checked every cycle, and a reference keystream generator.
module tb_a5_1_sequencer;

  localparam int KS_N = 228;
  localparam int K_KEY0 = 2;
  localparam int K_FRM0 = K_KEY0 + 64;
  localparam int K_MIX0 = K_FRM0 + 22;
  localparam int K_STR0 = K_MIX0 + 101;

  logic clk = 1'b0;
  logic reset, start, abort, ks_ready;
  logic [63:0] key;
  logic [21:0] frame;
  logic busy, done, reg_clear;
  logic x_shift_bit, y_shift_bit, z_shift_bit;
  logic x_trigger, y_trigger, z_trigger;
  logic x_out, y_out, z_out, x_maj, y_maj, z_maj;
  logic ks_bit, ks_valid, ks_last;

  logic [18:0] rx;
  logic [21:0] ry;
  logic [22:0] rz;
  logic        forced;
  logic [5:0]  fv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  a5_1_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .key(key), .frame(frame),
    .busy(busy), .done(done), .reg_clear(reg_clear),
    .x_shift_bit(x_shift_bit), .y_shift_bit(y_shift_bit), .z_shift_bit(z_shift_bit),
    .x_trigger(x_trigger), .y_trigger(y_trigger), .z_trigger(z_trigger),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .x_maj(x_maj), .y_maj(y_maj), .z_maj(z_maj),
    .ks_bit(ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_last(ks_last)
  );

  // Behavioural LFSRs: cleared by reset or reg_clear, shifted when triggered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx <= '0; ry <= '0; rz <= '0;
    end else if (reg_clear) begin
      rx <= '0; ry <= '0; rz <= '0;
    end else begin
      if (x_trigger) rx <= {rx[17:0], (^(rx & 19'h72000)) ^ x_shift_bit};
      if (y_trigger) ry <= {ry[20:0], (^(ry & 22'h300000)) ^ y_shift_bit};
      if (z_trigger) rz <= {rz[21:0], (^(rz & 23'h700080)) ^ z_shift_bit};
    end
  end

  assign x_out = forced ? fv[5] : rx[18];
  assign y_out = forced ? fv[4] : ry[21];
  assign z_out = forced ? fv[3] : rz[22];
  assign x_maj = forced ? fv[2] : rx[8];
  assign y_maj = forced ? fv[1] : ry[10];
  assign z_maj = forced ? fv[0] : rz[10];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference keystream, written like the classic C model
  function automatic logic [227:0] a5_ref(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;
    logic [227:0] ks;
    logic b, m;
    r1 = '0; r2 = '0; r3 = '0; ks = '0;
    for (int i = 0; i < 86; i++) begin
      if (i < 64) b = k[i];
      else b = f[i-64];
      r1 = {r1[17:0], (^(r1 & 19'h72000)) ^ b};
      r2 = {r2[20:0], (^(r2 & 22'h300000)) ^ b};
      r3 = {r3[21:0], (^(r3 & 23'h700080)) ^ b};
    end
    for (int i = 0; i < 100 + KS_N; i++) begin
      m = (int'(r1[8]) + int'(r2[10]) + int'(r3[10])) >= 2;
      if (r1[8] == m)  r1 = {r1[17:0], ^(r1 & 19'h72000)};
      if (r2[10] == m) r2 = {r2[20:0], ^(r2 & 22'h300000)};
      if (r3[10] == m) r3 = {r3[21:0], ^(r3 & 23'h700080)};
      if (i >= 100) ks[i-100] = r1[18] ^ r2[21] ^ r3[22];
    end
    return ks;
  endfunction

  function automatic logic [113:0] pack114(input logic [227:0] ks, input int base);
    logic [113:0] v;
    for (int i = 0; i < 114; i++) v[113-i] = ks[base+i];
    return v;
  endfunction

  // Timeline model: cycle offset since start acceptance decides the expected phase
  logic        m_active = 1'b0;
  logic        m_done = 1'b0;
  int          m_k = 0;
  int          m_sent = 0;
  logic [63:0] m_key = '0;
  logic [21:0] m_frame = '0;
  logic [227:0] m_ks = '0;

  initial begin
    logic st_key, st_frm, st_mix, st_str, mj, sb, nd;
    logic [2:0] mt, et;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_active = 1'b0;
        m_done   = 1'b0;
      end
      st_key = m_active && m_k >= K_KEY0 && m_k < K_FRM0;
      st_frm = m_active && m_k >= K_FRM0 && m_k < K_MIX0;
      st_mix = m_active && m_k >= K_MIX0 && m_k < K_STR0;
      st_str = m_active && m_k >= K_STR0;
      mj = (int'(x_maj) + int'(y_maj) + int'(z_maj)) >= 2;
      mt = {x_maj == mj, y_maj == mj, z_maj == mj};
      if (st_key || st_frm) et = 3'b111;
      else if (st_mix || (st_str && ks_ready)) et = mt;
      else et = 3'b000;
      if (st_key) sb = m_key[m_k-K_KEY0];
      else if (st_frm) sb = m_frame[m_k-K_FRM0];
      else sb = 1'b0;
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("reg_clear", reg_clear, m_active && m_k == 1);
      chk("triggers", {x_trigger, y_trigger, z_trigger}, et);
      chk("shift_bits", {x_shift_bit, y_shift_bit, z_shift_bit}, {3{sb}});
      chk("ks_valid", ks_valid, st_str);
      chk("ks_last", ks_last, st_str && m_sent == KS_N - 1);
      if (st_str) chk("ks_bit", ks_bit, forced ? (x_out ^ y_out ^ z_out) : m_ks[m_sent]);
      nd = 1'b0;
      if (reset || abort) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1'b1; m_k = 1; m_sent = 0;
          m_key = key; m_frame = frame; m_ks = a5_ref(key, frame);
        end
      end else if (!st_str) begin
        m_k++;
      end else if (ks_ready) begin
        if (m_sent == KS_N - 1) begin
          m_active = 1'b0; nd = 1'b1;
        end else begin
          m_sent++;
        end
      end
      m_done = nd;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic session(input logic [63:0] k, input logic [21:0] f, input int abort_at,
                         input int stall_at, input bit rnd, output int nxf,
                         output logic [227:0] got, output int lat, output bit saw_done);
    int stalls;
    bit ended;
    key = k; frame = f; start = 1'b1;
    cyc();
    start = 1'b0; key = ~k; frame = ~f;
    nxf = 0; got = '0; lat = 0; saw_done = 1'b0; stalls = 0; ended = 1'b0;
    for (int c = 1; c < 3000 && !ended; c++) begin
      if (stall_at >= 0 && nxf == stall_at && stalls < 5 && ks_valid) begin
        ks_ready = 1'b0; stalls++;
      end else begin
        ks_ready = rnd ? ($urandom % 3 != 0) : 1'b1;
      end
      abort = (abort_at >= 0 && nxf == abort_at && ks_valid);
      start = busy && nxf < 200 && ($urandom % 40 == 0);
      key = {$urandom, $urandom};
      #1;
      if (ks_valid && lat == 0) lat = c;
      if (ks_valid && ks_ready) begin
        if (nxf < KS_N) got[nxf] = ks_bit;
        nxf++;
      end
      if (done) begin
        saw_done = 1'b1; ended = 1'b1;
      end else if (abort) begin
        cyc(); ended = 1'b1;
      end else begin
        cyc();
      end
    end
    if (!ended) chk("session_timeout", 1'b0, 1'b1);
    ks_ready = 1'b0; abort = 1'b0; start = 1'b0;
  endtask

  initial begin
    logic [227:0] r, got;
    logic [119:0] lit_a, lit_b;
    logic [63:0]  kb, k;
    logic [21:0]  fb, f;
    int nxf, lat, mixlen, ab;
    bit sd, trig_ok;

    reset = 1'b1; start = 1'b0; abort = 1'b0; ks_ready = 1'b0;
    key = '0; frame = '0; forced = 1'b0; fv = '0;
    cyc(); cyc();
    chk("reset_outputs", {busy, done, reg_clear, x_trigger, y_trigger, z_trigger,
        x_shift_bit, y_shift_bit, z_shift_bit, ks_valid, ks_last, ks_bit}, '0);
    reset = 1'b0;
    cyc();

    // Pin the reference against the published A5/1 test vector
    lit_a = 120'h534EAA582FE8151AB6E1855A728C00;
    lit_b = 120'h24FD35A35D5FB6526D32F906DF1AC0;
    r = a5_ref(64'hEFCDAB8967452312, 22'h134);
    chk("ref_atob", pack114(r, 0), lit_a[119:6]);
    chk("ref_btoa", pack114(r, 114), lit_b[119:6]);
    chk("ref_zero_key", a5_ref(64'h0, 22'h0), '0);

    // Load phases, then forced-tap majority checks and MIX length
    key = 64'h0123456789ABCDEF; frame = 22'h134; start = 1'b1;
    cyc();
    start = 1'b0; key = '0; frame = '0;
    cyc();
    trig_ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      kb[i] = x_shift_bit;
      trig_ok &= ({x_trigger, y_trigger, z_trigger} == 3'b111);
      cyc();
    end
    for (int i = 0; i < 22; i++) begin
      fb[i] = y_shift_bit;
      trig_ok &= ({x_trigger, y_trigger, z_trigger} == 3'b111);
      cyc();
    end
    chk("key_first8", kb[7:0], 8'hEF);
    chk("key_bits", kb, 64'h0123456789ABCDEF);
    chk("frame_bits", fb, 22'h134);
    chk("load_triggers", trig_ok, 1'b1);
    forced = 1'b1; fv = 6'b000110;
    #1 chk("mix_taps_110", {x_trigger, y_trigger, z_trigger}, 3'b110);
    cyc();
    fv = 6'b000000;
    #1 chk("mix_taps_000", {x_trigger, y_trigger, z_trigger}, 3'b111);
    mixlen = 2;
    for (int i = 0; i < 300; i++) begin
      cyc();
      fv = 6'($urandom);
      #1;
      if (ks_valid) break;
      mixlen++;
    end
    chk("mix_length", mixlen, 101);
    abort = 1'b1;
    cyc();
    abort = 1'b0; forced = 1'b0; fv = '0;

    // Reset during KEY
    key = 64'hFFFF_0000_FFFF_0000; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (10) cyc();
    reset = 1'b1;
    #1 chk("reset_mid_key", {busy, x_trigger, y_trigger, z_trigger, done}, 5'b0);
    cyc();
    reset = 1'b0;
    cyc();

    // Zero key/frame, full-rate stream
    session(64'h0, 22'h0, -1, -1, 1'b0, nxf, got, lat, sd);
    chk("zero_transfers", nxf, KS_N);
    chk("zero_keystream", got, '0);
    chk("zero_latency", lat, 189);
    chk("zero_done", sd, 1'b1);
    cyc();
    chk("idle_after_done", {busy, done}, 2'b00);

    // Backpressure after the 10th transfer
    k = {$urandom, $urandom}; f = 22'($urandom);
    session(k, f, -1, 10, 1'b0, nxf, got, lat, sd);
    chk("bp_transfers", nxf, KS_N);
    chk("bp_keystream", got, a5_ref(k, f));

    // Named key, abort mid-stream, then the same session again
    session(64'h123456789ABCDEF0, 22'h2A, -1, -1, 1'b1, nxf, got, lat, sd);
    chk("named_keystream", got, a5_ref(64'h123456789ABCDEF0, 22'h2A));
    session(64'h123456789ABCDEF0, 22'h2A, 60, -1, 1'b1, nxf, got, lat, sd);
    chk("abort_no_done", sd, 1'b0);
    session(64'h123456789ABCDEF0, 22'h2A, -1, -1, 1'b1, nxf, got, lat, sd);
    chk("rerun_keystream", got, a5_ref(64'h123456789ABCDEF0, 22'h2A));
    chk("rerun_transfers", nxf, KS_N);

    // Published vector end to end
    session(64'hEFCDAB8967452312, 22'h134, -1, -1, 1'b1, nxf, got, lat, sd);
    chk("dut_atob", pack114(got, 0), lit_a[119:6]);
    chk("dut_btoa", pack114(got, 114), lit_b[119:6]);

    // Abort coinciding with the final transfer
    session(64'h5A5A_1234_0F0F_9876, 22'h3_0001, KS_N - 1, -1, 1'b0, nxf, got, lat, sd);
    chk("abort_final_no_done", sd, 1'b0);
    cyc();
    chk("abort_final_idle", {busy, done}, 2'b00);

    // Abort beats start in IDLE
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", busy, 1'b0);
    cyc();

    // Randomised sessions
    for (int s = 0; s < 4; s++) begin
      k = {$urandom, $urandom}; f = 22'($urandom);
      ab = ($urandom % 2 == 0) ? int'($urandom % KS_N) : -1;
      session(k, f, ab, -1, 1'b1, nxf, got, lat, sd);
      if (ab < 0) begin
        chk("rand_transfers", nxf, KS_N);
        chk("rand_keystream", got, a5_ref(k, f));
      end else begin
        chk("rand_abort_no_done", sd, 1'b0);
      end
      cyc();
    end

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
